// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU debug/step controller:
// state codes, operating modes and the fetch beat.
package cpu_dbg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BEAT  = 3'd1,
      ST_INSTR = 3'd2,
      ST_RUN   = 3'd3,
      ST_BRK   = 3'd4
   } state_e;

   localparam logic [1:0] MODE_HALT  = 2'b00;
   localparam logic [1:0] MODE_BEAT  = 2'b01;
   localparam logic [1:0] MODE_INSTR = 2'b10;
   localparam logic [1:0] MODE_RUN   = 2'b11;

   localparam logic [4:0] BEAT_FETCH = 5'b00001;

endpackage

// File: rtl/cpu_step_ctrl_btn_edge.sv
// Registered rising-edge detector for the step button.
// Ports: clk_i, rst_ni, btn_i (level) -> rise_o (one-cycle pulse).
module btn_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   logic btn_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) btn_q <= 1'b0;
      else         btn_q <= btn_i;
   end

   assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for the multi-cycle core: halt, beat-step,
// instruction-step and free run, plus cycle/instruction counters.
// Ports: clk, rstn, mode, step_btn, beat, pc, bp_addr, bp_en in;
// cpu_ce, halted, bp_hit, fault, cycle_cnt, instr_cnt, state_o out.
// Macro CPU_STEP_BREAKPOINT_EN compiles in the PC breakpoint (BRK).
module cpu_step_ctrl #(
   parameter int unsigned RUN_DIV   = 1,
   parameter int unsigned MAX_BEATS = 8,
   parameter int unsigned PC_W      = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [1:0]      mode,
   input  logic            step_btn,
   input  logic [4:0]      beat,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] bp_addr,
   input  logic            bp_en,
   output logic            cpu_ce,
   output logic            halted,
   output logic            bp_hit,
   output logic            fault,
   output logic [15:0]     cycle_cnt,
   output logic [15:0]     instr_cnt,
   output logic [2:0]      state_o
);
   import cpu_dbg_pkg::*;

   localparam int unsigned BW = $clog2(MAX_BEATS + 1);
   localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);
   localparam logic [BW-1:0] BEATS_MAX = BW'(MAX_BEATS);

   state_e        state_q, state_d;
   logic          started_q, started_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [15:0]   div_q, div_d;
   logic          fault_q, fault_d;
   logic [15:0]   cycle_q, instr_q;
   logic          ce;
   logic          rise;
   logic          fetch;
   logic          bp_match;

   assign fetch = (beat == BEAT_FETCH);

   btn_edge u_btn (
      .clk_i  (clk),
      .rst_ni (rstn),
      .btn_i  (step_btn),
      .rise_o (rise)
   );

`ifdef CPU_STEP_BREAKPOINT_EN
   logic skip_q, skip_d;
   // skip lets the fetch we just stopped on be enabled once after resume
   assign bp_match = bp_en && fetch && (pc == bp_addr) && !skip_q;
`else
   logic unused_bp;
   assign bp_match  = 1'b0;
   assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

   always_comb begin
      state_d   = state_q;
      started_d = started_q;
      beats_d   = beats_q;
      div_d     = div_q;
      fault_d   = fault_q;
      ce        = 1'b0;
`ifdef CPU_STEP_BREAKPOINT_EN
      skip_d    = skip_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            started_d = 1'b0;
            beats_d   = '0;
            div_d     = '0;
            if (mode == MODE_RUN) begin
               state_d = ST_RUN;
`ifdef CPU_STEP_BREAKPOINT_EN
               skip_d  = 1'b1;
`endif
            end else if (rise && mode == MODE_BEAT) begin
               state_d = ST_BEAT;
            end else if (rise && mode == MODE_INSTR) begin
               state_d = ST_INSTR;
            end
         end
         ST_BEAT: begin
            ce      = 1'b1;
            state_d = ST_IDLE;
         end
         ST_INSTR: begin
            if (started_q && fetch) begin
               state_d = ST_IDLE;
            end else if (beats_q == BEATS_MAX) begin
               fault_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ce        = 1'b1;
               started_d = 1'b1;
               beats_d   = beats_q + BW'(1);
            end
         end
         ST_RUN: begin
            if (mode != MODE_RUN) begin
               state_d = ST_IDLE;
            end else if (bp_match) begin
               state_d = ST_BRK;
            end else if (div_q == DIV_LAST) begin
               ce    = 1'b1;
               div_d = '0;
`ifdef CPU_STEP_BREAKPOINT_EN
               skip_d = 1'b0;
`endif
            end else begin
               div_d = div_q + 16'd1;
            end
         end
`ifdef CPU_STEP_BREAKPOINT_EN
         ST_BRK: begin
            if (mode != MODE_RUN) begin
               state_d = ST_IDLE;
            end else if (rise) begin
               state_d = ST_RUN;
               div_d   = '0;
               skip_d  = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         started_q <= 1'b0;
         beats_q   <= '0;
         div_q     <= '0;
         fault_q   <= 1'b0;
         cycle_q   <= '0;
         instr_q   <= '0;
      end else begin
         state_q   <= state_d;
         started_q <= started_d;
         beats_q   <= beats_d;
         div_q     <= div_d;
         fault_q   <= fault_d;
         if (ce) cycle_q <= cycle_q + 16'd1;
         if (ce && fetch) instr_q <= instr_q + 16'd1;
      end
   end

`ifdef CPU_STEP_BREAKPOINT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) skip_q <= 1'b0;
      else       skip_q <= skip_d;
   end
   assign bp_hit = (state_q == ST_BRK);
`else
   assign bp_hit = 1'b0;
`endif

   assign cpu_ce    = ce;
   assign halted    = (state_q != ST_RUN);
   assign fault     = fault_q;
   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a small core model
// that advances its beat/pc on every cpu_ce.
module tb_cpu_step_ctrl;
   import cpu_dbg_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  mode, mode4;
   logic        step_btn;
   logic [4:0]  beat;
   logic [31:0] pc;
   logic [31:0] bp_addr;
   logic        bp_en;
   logic        cpu_ce, halted, bp_hit, fault;
   logic [15:0] cycle_cnt, instr_cnt;
   logic [2:0]  state_o;
   logic        ce4, halted4, bp_hit4, fault4;
   logic [15:0] cyc4, ins4;
   logic [2:0]  state4;

   int n_cmp = 0;
   int n_bad = 0;

   int idx = 0;
   int nb = 4;
   bit stuck = 0;
   bit ce_n = 0;
   int ce_seen = 0;

   always #5 clk = ~clk;

   cpu_step_ctrl #(.RUN_DIV(1), .MAX_BEATS(8), .PC_W(32)) u_dut (
      .clk(clk), .rstn(rstn), .mode(mode), .step_btn(step_btn),
      .beat(beat), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
      .cpu_ce(cpu_ce), .halted(halted), .bp_hit(bp_hit),
      .fault(fault), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
      .state_o(state_o)
   );

   cpu_step_ctrl #(.RUN_DIV(4), .MAX_BEATS(8), .PC_W(32)) u_div4 (
      .clk(clk), .rstn(rstn), .mode(mode4), .step_btn(step_btn),
      .beat(beat), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
      .cpu_ce(ce4), .halted(halted4), .bp_hit(bp_hit4),
      .fault(fault4), .cycle_cnt(cyc4), .instr_cnt(ins4),
      .state_o(state4)
   );

   assign beat = stuck ? 5'b00010 : 5'(1 << idx);

   always @(negedge clk) begin
      ce_n = rstn && cpu_ce;
      if (rstn && cpu_ce) ce_seen++;
   end

   // core model: one beat per enable, pc += 4 per finished instruction
   always begin
      @(posedge clk);
      #1;
      if (!rstn) begin
         idx = 0;
         pc  = 0;
      end else if (ce_n && !stuck) begin
         if (idx >= nb - 1) begin
            idx = 0;
            pc  = pc + 4;
         end else begin
            idx++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rstn = 1'b0;
      mode = MODE_HALT;
      mode4 = MODE_HALT;
      step_btn = 1'b0;
      nb = 4;
      repeat (3) tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic do_step(input logic [1:0] m, input int hold,
                          input bit stk, output int nce);
      int c0;
      stuck = stk;
      tick();
      c0 = ce_seen;
      mode = m;
      step_btn = 1'b1;
      repeat (hold) tick();
      step_btn = 1'b0;
      repeat (16) tick();
      mode = MODE_HALT;
      stuck = 0;
      @(negedge clk);
      nce = ce_seen - c0;
   endtask

   typedef struct {
      logic [1:0] m;
      int         hold;
      bit         stk;
      int         exp_ce;
      int         exp_ins;
      bit         exp_fault;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int cum_c, cum_i, nce, c0, T, f, op, eins, ece;
      bit hit, fexp;

      tbl[0] = '{MODE_BEAT,  10, 1'b0, 1, 1, 1'b0};
      tbl[1] = '{MODE_BEAT,   1, 1'b0, 1, 0, 1'b0};
      tbl[2] = '{MODE_INSTR,  3, 1'b0, 2, 0, 1'b0};
      tbl[3] = '{MODE_INSTR,  1, 1'b0, 4, 1, 1'b0};
      tbl[4] = '{MODE_HALT,   3, 1'b0, 0, 0, 1'b0};
      tbl[5] = '{MODE_INSTR,  2, 1'b1, 8, 0, 1'b1};

      rstn = 1'b0;
      mode = MODE_RUN;
      mode4 = MODE_HALT;
      step_btn = 1'b0;
      bp_addr = 32'h0;
      bp_en = 1'b0;

      // reset held with mode=run
      repeat (3) @(negedge clk);
      chk("rst_ce", cpu_ce, 0);
      chk("rst_halted", halted, 1);
      chk("rst_bphit", bp_hit, 0);
      chk("rst_fault", fault, 0);
      chk("rst_cyc", cycle_cnt, 0);
      chk("rst_ins", instr_cnt, 0);
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("rel_idle_ce", cpu_ce, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("run_div1_ce", cpu_ce, 1);
      end
      tick();
      mode = MODE_HALT;
      @(negedge clk);
      chk("run_drop_ce", cpu_ce, 0);
      @(negedge clk);
      chk("run_drop_halt", halted, 1);
      chk("run_cyc", cycle_cnt, 5);
      chk("run_ins", instr_cnt, 2);

      // table-driven step vectors
      do_reset();
      cum_c = 0;
      cum_i = 0;
      for (int r = 0; r < 6; r++) begin
         do_step(tbl[r].m, tbl[r].hold, tbl[r].stk, nce);
         cum_c += tbl[r].exp_ce;
         cum_i += tbl[r].exp_ins;
         chk($sformatf("tbl%0d_ce", r), nce, tbl[r].exp_ce);
         chk($sformatf("tbl%0d_cyc", r), cycle_cnt, cum_c);
         chk($sformatf("tbl%0d_ins", r), instr_cnt, cum_i);
         chk($sformatf("tbl%0d_fault", r), fault, tbl[r].exp_fault);
         chk($sformatf("tbl%0d_state", r), state_o, ST_IDLE);
      end

      // step latency: press seen at one edge, enable in next cycle
      tick();
      fexp = (idx == 0);
      mode = MODE_BEAT;
      step_btn = 1'b1;
      @(negedge clk);
      chk("lat_c0", cpu_ce, 0);
      @(negedge clk);
      chk("lat_c1", cpu_ce, 1);
      chk("lat_state", state_o, ST_BEAT);
      @(negedge clk);
      chk("lat_c2", cpu_ce, 0);
      tick();
      step_btn = 1'b0;
      mode = MODE_HALT;
      cum_c += 1;
      cum_i += fexp ? 1 : 0;

      // randomized operations against the transaction-level model
      for (int n = 0; n < 40; n++) begin
         if (idx == 0 && $urandom_range(0, 2) == 0)
            nb = $urandom_range(1, 5);
         op = $urandom_range(0, 3);
         if (op == 0) begin
            ece = 1;
            eins = (idx == 0) ? 1 : 0;
            do_step(MODE_BEAT, $urandom_range(1, 4), 1'b0, nce);
         end else if (op == 1) begin
            ece = (idx == 0) ? nb : nb - idx;
            eins = (idx == 0) ? 1 : 0;
            do_step(MODE_INSTR, $urandom_range(1, 4), 1'b0, nce);
         end else if (op == 2) begin
            T = $urandom_range(2, 9);
            ece = T - 1;
            eins = 0;
            for (int j = 0; j < T - 1; j++)
               if ((idx + j) % nb == 0) eins++;
            tick();
            c0 = ce_seen;
            mode = MODE_RUN;
            repeat (T) tick();
            mode = MODE_HALT;
            repeat (3) tick();
            @(negedge clk);
            nce = ce_seen - c0;
         end else begin
            ece = 0;
            eins = 0;
            do_step(MODE_HALT, $urandom_range(1, 4), 1'b0, nce);
         end
         cum_c += ece;
         cum_i += eins;
         chk($sformatf("rnd%0d_op%0d_ce", n, op), nce, ece);
         chk($sformatf("rnd%0d_cyc", n), cycle_cnt, 16'(cum_c));
         chk($sformatf("rnd%0d_ins", n), instr_cnt, 16'(cum_i));
      end

      // breakpoint
      do_reset();
      bp_addr = 32'h0C;
      bp_en = 1'b1;
`ifdef CPU_STEP_BREAKPOINT_EN
      mode = MODE_RUN;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge clk);
         if (bp_hit) hit = 1;
      end
      chk("bp_reached", hit, 1);
      chk("bp_ce", cpu_ce, 0);
      chk("bp_pc", pc, 32'h0C);
      chk("bp_cyc", cycle_cnt, 12);
      chk("bp_ins", instr_cnt, 3);
      repeat (3) @(negedge clk);
      chk("bp_hold_state", state_o, ST_BRK);
      chk("bp_hold_cyc", cycle_cnt, 12);
      tick();
      step_btn = 1'b1;
      tick();
      step_btn = 1'b0;
      hit = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bp_hit) hit = 1;
      end
      chk("bp_no_rehit", hit, 0);
      chk("bp_past", pc > 32'h0C, 1);
      chk("bp_resume_ins", instr_cnt > 16'd3, 1);
      tick();
      mode = MODE_HALT;
`else
      mode = MODE_RUN;
      hit = 0;
      repeat (30) begin
         tick();
         if (bp_hit) hit = 1;
      end
      mode = MODE_HALT;
      repeat (3) tick();
      chk("nobp_hit", hit, 0);
      chk("nobp_cyc", cycle_cnt, 29);
      chk("nobp_pc", pc, 32'h1C);
`endif
      bp_en = 1'b0;

      // RUN_DIV = 4 instance
      do_reset();
      mode4 = MODE_RUN;
      @(negedge clk);
      chk("div4_idle", ce4, 0);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk($sformatf("div4_k%0d", k), ce4, (k % 4 == 3) ? 1 : 0);
      end
      tick();
      mode4 = MODE_HALT;
      @(negedge clk);
      chk("div4_drop_ce", ce4, 0);
      @(negedge clk);
      chk("div4_drop_halt", halted4, 1);
      chk("div4_state", state4, ST_IDLE);
      chk("div4_cyc", cyc4, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Clock-enable sequencer that sits directly upstream of the multi-cycle CPU core (control FSM, PC, ALU, register file, memory). It produces `cpu_ce`, the single enable on which every core register advances, and supports four modes: halted, single-beat step, single-instruction step, and free run. Free run includes an optional PC breakpoint. It also keeps cycle and instruction counters for the seven-segment and LED debug display.

## Interface
Parameters:
- `RUN_DIV`, 1: in RUN mode, `cpu_ce` pulses once every `RUN_DIV` clk cycles (valid range 1..2^16).
- `MAX_BEATS`, 8: watchdog limit on enables per instruction step.
- `PC_W`, 32: PC width.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `mode`  in  2  operating mode: 00 halt, 01 beat-step, 10 instr-step, 11 run.
- `step_btn`  in  1  debounced step/resume button, level.
- `beat`  in  5  one-hot beat from the control FSM; 5'b00001 = fetch.
- `pc`  in  PC_W  current PC value.
- `bp_addr`  in  PC_W  breakpoint address.
- `bp_en`  in  1  breakpoint enable.
- `cpu_ce`  out  1  core clock enable.
- `halted`  out  1  high whenever state ≠ RUN.
- `bp_hit`  out  1  high while in BRK.
- `fault`  out  1  sticky; set by the instruction-step watchdog.
- `cycle_cnt`  out  16  number of `cpu_ce` pulses issued.
- `instr_cnt`  out  16  number of fetch beats enabled.
- `state_o`  out  3  state encoding, for display.

## Operation
- Rising-edge detect on `step_btn`: `edge = step_btn & ~btn_q`, where `btn_q` is `step_btn` registered on clk.
- States: IDLE, BEAT, INSTR, RUN, BRK.
- IDLE (`cpu_ce` = 0):
  - edge & mode=01 → BEAT.
  - edge & mode=10 → INSTR.
  - mode=11 → RUN (level-triggered; no button needed).
  - mode=00 → stays in IDLE.
- BEAT: `cpu_ce` = 1 for exactly one cycle, then → IDLE.
- INSTR:
  - `cpu_ce` = 1 every cycle until `started` is set and `beat` = fetch. In that cycle `cpu_ce` = 0 and the next state is IDLE.
  - `started` is set by the first enable.
  - If `MAX_BEATS` enables are issued without returning to fetch: `fault` ← 1, → IDLE.
  - INSTR ignores `mode` changes until it completes.
- RUN:
  - `cpu_ce` = 1 when the divider counter = `RUN_DIV`-1. The counter wraps at that point and is cleared when RUN is entered.
  - mode ≠ 11 → IDLE; `cpu_ce` = 0 in that cycle.
  - Breakpoint: `bp_en` & `beat` = fetch & `pc` = `bp_addr` & ~`skip` → BRK; `cpu_ce` = 0 in that cycle.
  - `skip` is set on every entry into RUN and cleared by the first enable.
- BRK (`cpu_ce` = 0): edge → RUN (with `skip` set); mode ≠ 11 → IDLE.
- `cpu_ce` is combinational from registered state, `started`, `skip`, the divider, `beat`, `pc`, `bp_*` and `mode`. There is no path from `step_btn` to `cpu_ce`.
- Counters:
  - `cycle_cnt` += 1 on each `cpu_ce`.
  - `instr_cnt` += 1 on `cpu_ce` & `beat` = fetch.
  - Both wrap modulo 2^16.
- Reset: state IDLE; `cpu_ce` 0; `halted` 1; `bp_hit` 0; `fault` 0; counters 0; `btn_q` 0; `started` 0; `skip` 0.
  - Reset mid-instruction abandons the step; the core is reset separately.

## Timing
- Step latency: the first clk edge that samples `step_btn` = 1 with `btn_q` = 0 enters BEAT or INSTR. `cpu_ce` is high in the following cycle.
- BEAT yields exactly one `cpu_ce` cycle per button press. Holding the button produces no further pulses.
- An INSTR step starting at fetch of an instruction with N beats yields N consecutive `cpu_ce` cycles.
- Breakpoint response is zero-cycle: the matching fetch beat is not enabled.

## Configuration
- `CPU_STEP_BREAKPOINT_EN` defined:
  - breakpoint compare, BRK state and `bp_hit` are compiled in.
- Not defined:
  - `bp_addr` and `bp_en` are ignored.
  - BRK is unreachable and removed.
  - `bp_hit` is tied to 0.
  - `skip` logic is removed.

## Structure
- Shared package `cpu_dbg_pkg`:
  - state encoding;
  - mode encodings (`MODE_HALT`, `MODE_BEAT`, `MODE_INSTR`, `MODE_RUN`);
  - `BEAT_FETCH` = 5'b00001.
- One sub-module: `btn_edge`, the registered rising-edge detector.

## Test plan
- Reset: hold `rstn` low with mode=11 → `cpu_ce` 0, `halted` 1, counters 0. Release → RUN; with `RUN_DIV`=1, `cpu_ce` high every cycle.
- mode=01, hold `step_btn` high for 10 cycles → exactly one `cpu_ce` cycle; `cycle_cnt` = 1.
- mode=10, beat model stepping 00001→00010→00100→01000→00001 → exactly 4 `cpu_ce` cycles; `instr_cnt` = 1; state returns to IDLE.
- mode=10, beat stuck at 00010 → 8 `cpu_ce` cycles, then `fault` = 1 and IDLE.
- RUN, `bp_en` = 1, `bp_addr` = 0x0C: pc reaches 0x0C at fetch → `cpu_ce` 0, `bp_hit` 1. Press button → fetch at 0x0C is enabled; pc advances past 0x0C without re-break.
- RUN with `RUN_DIV` = 4 → `cpu_ce` in every 4th cycle. Drop mode to 00 → `cpu_ce` 0 in the same cycle; IDLE next.
